// File: rtl/tetris_pkg.sv
// Shared piece codes and queue FSM states for the Tetris piece path.
package tetris_pkg;

    localparam int PIECE_W = 3;

    localparam logic [PIECE_W-1:0] PIECE_I    = 3'd0;
    localparam logic [PIECE_W-1:0] PIECE_O    = 3'd1;
    localparam logic [PIECE_W-1:0] PIECE_T    = 3'd2;
    localparam logic [PIECE_W-1:0] PIECE_S    = 3'd3;
    localparam logic [PIECE_W-1:0] PIECE_Z    = 3'd4;
    localparam logic [PIECE_W-1:0] PIECE_J    = 3'd5;
    localparam logic [PIECE_W-1:0] PIECE_L    = 3'd6;
    localparam logic [PIECE_W-1:0] PIECE_NONE = 3'd7;

    typedef enum logic [1:0] {
        ST_WARM,
        ST_FILL,
        ST_FULL
    } queue_state_e;

endpackage

// File: rtl/piece_fifo.sv
// Small circular FIFO of piece codes with two combinational read ports:
// the head entry and the one behind it (used for the preview).
module piece_fifo
    import tetris_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [PIECE_W-1:0]       data,
    input  logic                     pop,
    output logic [PIECE_W-1:0]       head,
    output logic                     head_valid,
    output logic [PIECE_W-1:0]       next,
    output logic                     next_valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PIECE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic               do_pop;
    logic               do_push;

    // Pops need a non-empty queue; a push into a full queue is only legal
    // when the head leaves at the same edge.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    // Storage array; contents are masked on read while invalid, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data;
        end
    end

    // Pointer and occupancy bookkeeping, pointers wrap naturally mod DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_valid = (count != '0);
    assign next_valid = (count > CNT_W'(1));
    assign head       = head_valid ? mem[rd_ptr] : '0;
    assign next       = next_valid ? mem[rd_ptr + PTR_W'(1)] : '0;

endmodule

// File: rtl/piece_queue.sv
// Consumer end of the LFSR path: warms up the LFSR, then turns rnd[2:0]
// into uniform piece codes 0..6 by rejecting 7, and keeps a FIFO of
// upcoming pieces (head for the game FSM, second entry for the preview).
// Optional feature macro NO_REPEAT_EN: a candidate equal to the last pushed
// piece is rejected once before being accepted.
module piece_queue
    import tetris_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int WARMUP_CYCLES = 8
) (
    input  logic                     vclk,
    input  logic                     rst,
    input  logic [7:0]               rnd,
    input  logic                     new_block,
    output logic                     rnd_step,
    output logic [PIECE_W-1:0]       piece,
    output logic                     piece_valid,
    output logic [PIECE_W-1:0]       next_piece,
    output logic                     next_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int WARM_W = $clog2(WARMUP_CYCLES) + 1;

    queue_state_e          state;
    queue_state_e          state_next;
    logic [WARM_W-1:0]     warm_cnt;
    logic                  warm_done;
    logic [PIECE_W-1:0]    candidate;
    logic                  accept;
    logic                  step;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      count_next;
    logic [7:PIECE_W]      unused_rnd_bits;

    assign unused_rnd_bits = rnd[7:PIECE_W];
    assign candidate       = rnd[PIECE_W-1:0];
    assign warm_done       = (warm_cnt == WARM_W'(WARMUP_CYCLES - 1));
    assign pop             = new_block && piece_valid;

`ifdef NO_REPEAT_EN
    logic [PIECE_W-1:0]    last;
    logic                  reroll_used;
    logic                  repeat_hit;
    logic                  sampled;

    assign repeat_hit = (candidate == last) && !reroll_used;
    assign accept     = (candidate != PIECE_NONE) && !repeat_hit;
    assign sampled    = step && (state != ST_WARM);

    // Remember the last pushed piece and whether its one reroll is spent.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            last        <= PIECE_NONE;
            reroll_used <= 1'b0;
        end else if (sampled) begin
            if (push) begin
                last        <= candidate;
                reroll_used <= 1'b0;
            end else if (candidate != PIECE_NONE) begin
                reroll_used <= 1'b1;
            end
        end
    end
`else
    assign accept = (candidate != PIECE_NONE);
`endif

    // Next-state, strobe and push decisions; FILL/FULL follow the new count.
    always_comb begin
        state_next = state;
        step       = 1'b0;
        push       = 1'b0;
        count_next = count;
        case (state)
            ST_WARM: begin
                step = 1'b1;
                if (warm_done) begin
                    state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                step = 1'b1;
                push = accept;
            end
            ST_FULL: begin
                step = new_block;
                push = new_block && accept;
            end
            default: begin
                state_next = ST_WARM;
            end
        endcase
        count_next = count + CNT_W'(push) - CNT_W'(pop);
        if (state == ST_FILL || state == ST_FULL) begin
            state_next = (count_next == CNT_W'(DEPTH)) ? ST_FULL : ST_FILL;
        end
    end

    // State register, warm-up counter and sticky underflow flag.
    always_ff @(posedge vclk or posedge rst) begin
        if (rst) begin
            state     <= ST_WARM;
            warm_cnt  <= '0;
            underflow <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_WARM && !warm_done) begin
                warm_cnt <= warm_cnt + WARM_W'(1);
            end
            if (new_block && !piece_valid) begin
                underflow <= 1'b1;
            end
        end
    end

    // The strobe must stay quiet while reset is held, even though WARM strobes.
    assign rnd_step = step && !rst;

    piece_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (vclk),
        .rst        (rst),
        .push       (push),
        .data       (candidate),
        .pop        (pop),
        .head       (piece),
        .head_valid (piece_valid),
        .next       (next_piece),
        .next_valid (next_valid),
        .count      (count)
    );

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_piece_queue;

    localparam int DEPTH = 4;
    localparam int WARM  = 8;

    logic       vclk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rnd = 8'h00;
    logic       new_block = 1'b0;
    logic       rnd_step;
    logic [2:0] piece;
    logic       piece_valid;
    logic [2:0] next_piece;
    logic       next_valid;
    logic [2:0] count;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    int q[$];
    int warm_left;
    int last;
    bit reroll;
    bit uf;

    piece_queue #(
        .DEPTH(DEPTH),
        .WARMUP_CYCLES(WARM)
    ) dut (
        .vclk        (vclk),
        .rst         (rst),
        .rnd         (rnd),
        .new_block   (new_block),
        .rnd_step    (rnd_step),
        .piece       (piece),
        .piece_valid (piece_valid),
        .next_piece  (next_piece),
        .next_valid  (next_valid),
        .count       (count),
        .underflow   (underflow)
    );

    initial forever #5 vclk = ~vclk;

    task automatic expect_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_step(input bit nb);
        if (warm_left > 0) return 1;
        if (q.size() < DEPTH) return 1;
        return int'(nb);
    endfunction

    task automatic model_reset();
        warm_left = WARM;
        q.delete();
        last   = 7;
        reroll = 1'b0;
        uf     = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held during the cycle.
    task automatic model_update(input logic [7:0] r, input bit nb);
        int c;
        int stp;
        c = int'(r[2:0]);
        if (warm_left > 0) begin
            warm_left--;
            if (nb) uf = 1'b1;
        end else begin
            stp = m_step(nb);
            if (nb) begin
                if (q.size() > 0) void'(q.pop_front());
                else uf = 1'b1;
            end
            if (stp == 1 && c != 7) begin
`ifdef NO_REPEAT_EN
                if (c == last && !reroll) begin
                    reroll = 1'b1;
                end else begin
                    q.push_back(c);
                    last   = c;
                    reroll = 1'b0;
                end
`else
                q.push_back(c);
`endif
            end
        end
    endtask

    task automatic checkOutput();
        int hd;
        int nx;
        hd = (q.size() > 0) ? q[0] : 0;
        nx = (q.size() > 1) ? q[1] : 0;
        expect_val("rnd_step", int'(rnd_step), m_step(new_block));
        expect_val("piece_valid", int'(piece_valid), int'(q.size() > 0));
        expect_val("piece", int'(piece), hd);
        expect_val("next_valid", int'(next_valid), int'(q.size() > 1));
        expect_val("next_piece", int'(next_piece), nx);
        expect_val("count", int'(count), q.size());
        expect_val("underflow", int'(underflow), int'(uf));
    endtask

    task automatic applyStimulus(input logic [7:0] r, input bit nb);
        @(negedge vclk);
        rnd = r;
        new_block = nb;
        #1;
        checkOutput();
        @(posedge vclk);
        model_update(r, nb);
        #1;
    endtask

    // Pulse reset around a negedge and run the first warm-up edge.
    task automatic reset_to(input logic [7:0] r);
        @(negedge vclk);
        rst = 1'b1;
        new_block = 1'b0;
        rnd = r;
        #1;
        model_reset();
        expect_val("rst_rnd_step", int'(rnd_step), 0);
        expect_val("rst_count", int'(count), 0);
        expect_val("rst_piece_valid", int'(piece_valid), 0);
        expect_val("rst_underflow", int'(underflow), 0);
        #2;
        rst = 1'b0;
        #1;
        checkOutput();
        @(posedge vclk);
        model_update(r, 1'b0);
        #1;
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] prev;
        bit         nb;

        // Warm-up and fill with a constant 5.
        reset_to(8'h05);
        for (int i = 0; i < WARM - 1; i++) applyStimulus(8'h05, 1'b0);
        expect_val("warm_piece_valid", int'(piece_valid), 0);
        expect_val("warm_count", int'(count), 0);
        applyStimulus(8'h05, 1'b0);
        expect_val("first_valid", int'(piece_valid), 1);
        expect_val("first_piece", int'(piece), 5);
`ifdef NO_REPEAT_EN
        for (int i = 0; i < 6; i++) applyStimulus(8'h05, 1'b0);
`else
        for (int i = 0; i < 3; i++) applyStimulus(8'h05, 1'b0);
`endif
        expect_val("full_count", int'(count), 4);
        expect_val("full_piece", int'(piece), 5);
        expect_val("full_next", int'(next_piece), 5);
        expect_val("full_rnd_step", int'(rnd_step), 0);

        // Pop from a full queue with rnd=2 held.
        applyStimulus(8'h02, 1'b1);
`ifndef NO_REPEAT_EN
        expect_val("pop_count", int'(count), 4);
        expect_val("pop_piece", int'(piece), 5);
`endif
        applyStimulus(8'h02, 1'b0);
`ifndef NO_REPEAT_EN
        expect_val("pop_idle_step", int'(rnd_step), 0);
`endif
        for (int i = 0; i < 3; i++) applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h02, 1'b0);
`ifndef NO_REPEAT_EN
        expect_val("refill_piece", int'(piece), 2);
        expect_val("refill_next", int'(next_piece), 2);
        expect_val("refill_count", int'(count), 4);
`endif

        // Only 7s after warm-up: nothing pushed, strobe keeps running; underflow.
        reset_to(8'h07);
        for (int i = 0; i < WARM - 1; i++) applyStimulus(8'h07, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h07, 1'b0);
        expect_val("reject_count", int'(count), 0);
        expect_val("reject_step", int'(rnd_step), 1);
        expect_val("pre_underflow", int'(underflow), 0);
        applyStimulus(8'h07, 1'b1);
        expect_val("underflow_set", int'(underflow), 1);
        expect_val("underflow_count", int'(count), 0);
        applyStimulus(8'h07, 1'b0);
        applyStimulus(8'h07, 1'b0);
        expect_val("underflow_sticky", int'(underflow), 1);

        // Repeated 3,3,3 after warm-up.
        reset_to(8'h07);
        for (int i = 0; i < WARM - 1; i++) applyStimulus(8'h07, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h07, 1'b0);
`ifdef NO_REPEAT_EN
        expect_val("repeat_count", int'(count), 2);
`else
        expect_val("repeat_count", int'(count), 3);
`endif
        expect_val("repeat_piece", int'(piece), 3);
        expect_val("repeat_next", int'(next_piece), 3);

        // Asynchronous reset with three pieces queued.
        reset_to(8'h07);
        for (int i = 0; i < WARM - 1; i++) applyStimulus(8'h07, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'h02, 1'b0);
        applyStimulus(8'h03, 1'b0);
        applyStimulus(8'h07, 1'b0);
        expect_val("pre_rst_count", int'(count), 3);
        expect_val("pre_rst_piece", int'(piece), 1);
        expect_val("pre_rst_next", int'(next_piece), 2);
        #2;
        rst = 1'b1;
        #1;
        expect_val("async_count", int'(count), 0);
        expect_val("async_piece_valid", int'(piece_valid), 0);
        expect_val("async_next_valid", int'(next_valid), 0);
        expect_val("async_rnd_step", int'(rnd_step), 0);
        @(posedge vclk);
        #1;
        expect_val("held_rnd_step", int'(rnd_step), 0);
        expect_val("held_count", int'(count), 0);

        // Random traffic against the model, with occasional resets.
        reset_to(8'($urandom));
        prev = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_to(8'($urandom));
            end
            r  = ($urandom_range(0, 3) == 0) ? prev : 8'($urandom);
            nb = ($urandom_range(0, 3) == 0);
            prev = r;
            applyStimulus(r, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
